// File: rtl/dmem_responder.sv
// Data-port responder: turns single-cycle core loads/stores into valid/ready
// backing-memory transactions, with a one-word last-read buffer for repeat reads.
module dmem_responder #(
  parameter int MEM_AW = 30,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       dcache_addr,
  input  logic              dcache_re,
  input  logic [3:0]        dcache_we,
  input  logic [31:0]       dcache_din,
  output logic [31:0]       dcache_dout,
  output logic              stall,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_rw,
  output logic [MEM_AW-1:0] mem_req_addr,
  output logic [31:0]       mem_req_data,
  output logic [3:0]        mem_req_mask,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_data,
  output logic [CNT_W-1:0]  stall_cycles
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_REQ  = 2'd1;
  localparam logic [1:0] RD_WAIT = 2'd2;
  localparam logic [1:0] WR_REQ  = 2'd3;

  logic [1:0]        r_state;
  logic [MEM_AW-1:0] r_req_addr;
  logic [31:0]       r_req_data;
  logic [3:0]        r_req_mask;
  logic              r_req_rw;
  logic [31:0]       r_dout;
  logic              r_buf_valid;
  logic [MEM_AW-1:0] r_buf_tag;
  logic [31:0]       r_buf_data;
  logic [CNT_W-1:0]  r_stall_cycles;

  logic [MEM_AW-1:0] w_word_addr;
  logic              w_tag_hit;
  logic [31:0]       w_merged;
  logic              w_unused;

  assign w_word_addr = dcache_addr[MEM_AW+1:2];
  assign w_tag_hit   = r_buf_valid && (r_buf_tag == w_word_addr);
  assign w_unused    = ^dcache_addr[1:0];

  // Write-through merge of the store's enabled byte lanes into the buffered word.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_merge
      assign w_merged[8*gi +: 8] = dcache_we[gi] ? dcache_din[8*gi +: 8]
                                                 : r_buf_data[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_req_addr  <= '0;
      r_req_data  <= '0;
      r_req_mask  <= '0;
      r_req_rw    <= 1'b0;
      r_dout      <= '0;
      r_buf_valid <= 1'b0;
      r_buf_tag   <= '0;
      r_buf_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (dcache_we != 4'h0) begin
            r_state    <= WR_REQ;
            r_req_rw   <= 1'b1;
            r_req_addr <= w_word_addr;
            r_req_data <= dcache_din;
            r_req_mask <= dcache_we;
            if (w_tag_hit) r_buf_data <= w_merged;
          end else if (dcache_re) begin
            if (w_tag_hit) begin
              r_dout <= r_buf_data;
            end else begin
              r_state    <= RD_REQ;
              r_req_rw   <= 1'b0;
              r_req_addr <= w_word_addr;
              r_req_mask <= 4'h0;
            end
          end
        end
        RD_REQ: if (mem_req_ready) r_state <= RD_WAIT;
        RD_WAIT: begin
          if (mem_resp_valid) begin
            r_state     <= IDLE;
            r_dout      <= mem_resp_data;
            r_buf_data  <= mem_resp_data;
            r_buf_tag   <= r_req_addr;
            r_buf_valid <= 1'b1;
          end
        end
        WR_REQ: if (mem_req_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cycles <= '0;
    end else if ((r_state != IDLE) && !(&r_stall_cycles)) begin
      r_stall_cycles <= r_stall_cycles + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Valid is decoded from state so an asynchronous reset drops it at once.
  assign stall         = (r_state != IDLE);
  assign mem_req_valid = (r_state == RD_REQ) || (r_state == WR_REQ);
  assign mem_req_rw    = r_req_rw;
  assign mem_req_addr  = r_req_addr;
  assign mem_req_data  = r_req_data;
  assign mem_req_mask  = r_req_mask;
  assign dcache_dout   = r_dout;
  assign stall_cycles  = r_stall_cycles;

endmodule
